grant_burst_ctrl: RTL and testbench
===================================

# grant_burst_ctrl

Downstream consumer of the two-requester grant arbiter: turns the winning grant (`gnt_0`/`gnt_1`) into a fixed-length burst on a shared valid/ready bus. It pops words from the owning requester's source and pulses a per-requester done strobe on completion. It holds bus ownership for the whole burst, even if the grant changes mid-burst.

## Interface
- `DATA_W`, 8, width of requester data and bus data
- `BURST_LEN`, 4, beats per burst (>= 1)
- `TIMEOUT_CYC`, 16, consecutive stalled cycles before abort (used only with `GBC_TIMEOUT_EN`)

Ports:
- `clock`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `gnt_0`  in  1  grant to requester 0, from arbiter
- `gnt_1`  in  1  grant to requester 1, from arbiter
- `data_0`  in  DATA_W  head word of requester 0 source
- `data_1`  in  DATA_W  head word of requester 1 source
- `rd_0`  out  1  pop strobe to requester 0 source (combinational)
- `rd_1`  out  1  pop strobe to requester 1 source (combinational)
- `bus_valid`  out  1  bus word valid
- `bus_data`  out  DATA_W  bus word, mux of owner's data
- `bus_ready`  in  1  bus sink accepts word
- `bus_owner`  out  1  current/last owner (0 or 1)
- `done_0`  out  1  one-cycle pulse, requester 0 burst finished
- `done_1`  out  1  one-cycle pulse, requester 1 burst finished
- `busy`  out  1  high in XFER or DONE
- `timeout_err`  out  1  sticky abort flag

## Operation
- FSM states: IDLE, XFER, DONE. Encoded in the state register. `bus_valid`, `busy`, `done_*` decode from registered state/owner only.
- IDLE:
  - if `gnt_0`: owner←0, beat←0, go XFER.
  - else if `gnt_1`: owner←1, beat←0, go XFER.
  - `gnt_0` wins if both grants are high.
  - otherwise stay.
- XFER:
  - `bus_valid`=1; `bus_data`=owner ? `data_1` : `data_0`.
  - beat accepted = `bus_valid & bus_ready`.
  - `rd_owner` = beat accepted; `rd_other` = 0.
  - On an accepted beat: if beat==BURST_LEN-1 go DONE, else beat←beat+1.
- DONE: `done_owner`=1 for exactly this cycle, `bus_valid`=0, then IDLE unconditionally.
- Grants are ignored in XFER and DONE. A grant drop or switch mid-burst does not change the owner.
- A still-asserted grant (the arbiter holds grants sticky) starts a new burst from IDLE one cycle after DONE.
- Beat counter width: $clog2(BURST_LEN), minimum 1 bit. BURST_LEN=1 goes to DONE on the first accepted beat.
- `bus_data` is don't-care when `bus_valid`=0; the implementation drives the owner mux regardless.

## Timing
- Reset values: state IDLE, owner 0.
  - `bus_valid`=0, `bus_owner`=0, `busy`=0, `done_0`=`done_1`=0, `timeout_err`=0.
  - `rd_0`=`rd_1`=0, following from `bus_valid`=0.
- Grant sampled high at edge N in IDLE → `bus_valid`=1 from edge N.
- Minimum burst: 1 IDLE + BURST_LEN XFER + 1 DONE cycles = BURST_LEN+2. Back-to-back bursts with a held grant take BURST_LEN+2 cycles each.
- `bus_ready` low holds XFER. Beat, data, and `rd_*` do not advance while stalled.
- Reset asserted mid-burst: outputs return to reset values asynchronously. No done pulse is issued and the partial burst is dropped.
- Reset released with a grant high: a burst starts at the first edge after release.

## Configuration
- `GBC_TIMEOUT_EN` defined:
  - The stall counter increments each XFER cycle with `bus_valid & !bus_ready`. It clears on an accepted beat and on XFER entry.
  - On reaching TIMEOUT_CYC the block goes to DONE and sets `timeout_err`=1.
  - `timeout_err` is sticky until reset; the done pulse is still issued.
  - Counter width: $clog2(TIMEOUT_CYC+1).
- `GBC_TIMEOUT_EN` undefined: no stall counter, `timeout_err` tied 0, XFER waits indefinitely.

## Test plan
- Reset then `gnt_0`=1, `bus_ready`=1, `data_0` stepping 0x10..0x13 → 4 beats 0x10–0x13, `rd_0` high 4 cycles, `done_0` pulse at cycle 6, `done_1` stays 0.
- `gnt_1` pulsed for 1 cycle, `bus_ready` toggling 1/0 → burst completes with 4 accepted beats owned by requester 1. `bus_owner`=1, `rd_0` never high, `done_1` once.
- `gnt_0` and `gnt_1` high together → owner 0. Switch to `gnt_1` only mid-burst → owner stays 0 to DONE, next burst owner 1.
- Reset asserted at beat 2 of burst → `bus_valid`, `busy`, `rd_*` low immediately, no `done_*`. After release with `gnt_0` held, a fresh 4-beat burst runs.
- `GBC_TIMEOUT_EN`, TIMEOUT_CYC=16, `bus_ready`=0 → DONE after 16 stalled cycles, `timeout_err`=1 held through later bursts until reset.
- Without `GBC_TIMEOUT_EN`, `bus_ready`=0 for 100 cycles → still XFER, `timeout_err`=0. Then `bus_ready`=1 completes the burst normally.

Source files
------------

// File: rtl/grant_burst_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | grant_burst_ctrl_if : grant, source and bus signals of grant_burst_ctrl  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface grant_burst_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              gnt_0;
  logic              gnt_1;
  logic [DATA_W-1:0] data_0;
  logic [DATA_W-1:0] data_1;
  logic              rd_0;
  logic              rd_1;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              bus_ready;
  logic              bus_owner;
  logic              done_0;
  logic              done_1;
  logic              busy;
  logic              timeout_err;

  // master: the burst controller itself; slave: arbiter, sources and sink
  modport master (
    input  gnt_0, gnt_1, data_0, data_1, bus_ready,
    output rd_0, rd_1, bus_valid, bus_data, bus_owner,
           done_0, done_1, busy, timeout_err
  );

  modport slave (
    output gnt_0, gnt_1, data_0, data_1, bus_ready,
    input  rd_0, rd_1, bus_valid, bus_data, bus_owner,
           done_0, done_1, busy, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/grant_burst_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | grant_burst_ctrl : turns an arbiter grant into a fixed-length bus burst; |
// | optional stall abort when GBC_TIMEOUT_EN is defined.        Rev 1.0      |
// +--------------------------------------------------------------------------+
module grant_burst_ctrl #(
  parameter int DATA_W      = 8,
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  wire logic         clock,
  input  wire logic         reset,
  grant_burst_ctrl_if.master gbc
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] c_beat_last = BEAT_W'(BURST_LEN - 1);

  if (BURST_LEN < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("grant_burst_ctrl: BURST_LEN and TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic              owner_q;
  logic [BEAT_W-1:0] beat_q;
  logic              w_accept;
  logic [DATA_W-1:0] w_mux;

`ifdef GBC_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [STALL_W-1:0] c_stall_last = STALL_W'(TIMEOUT_CYC - 1);
  logic [STALL_W-1:0] stall_q;
  logic               terr_q;
`endif

  assign w_accept = (state_q == ST_XFER) && gbc.bus_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      beat_q  <= '0;
`ifdef GBC_TIMEOUT_EN
      stall_q <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef GBC_TIMEOUT_EN
          stall_q <= '0;
`endif
          beat_q <= '0;
          if (gbc.gnt_0) begin
            owner_q <= 1'b0;
            state_q <= ST_XFER;
          end else if (gbc.gnt_1) begin
            owner_q <= 1'b1;
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          // Owner is frozen here: grants are not looked at until IDLE.
          if (w_accept) begin
`ifdef GBC_TIMEOUT_EN
            stall_q <= '0;
`endif
            if (beat_q == c_beat_last) begin
              state_q <= ST_DONE;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
`ifdef GBC_TIMEOUT_EN
          else if (stall_q == c_stall_last) begin
            state_q <= ST_DONE;
            terr_q  <= 1'b1;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
`endif
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign w_mux          = owner_q ? gbc.data_1 : gbc.data_0;
  assign gbc.bus_data   = w_mux;
  assign gbc.bus_valid  = (state_q == ST_XFER);
  assign gbc.bus_owner  = owner_q;
  assign gbc.rd_0       = w_accept && !owner_q;
  assign gbc.rd_1       = w_accept && owner_q;
  assign gbc.done_0     = (state_q == ST_DONE) && !owner_q;
  assign gbc.done_1     = (state_q == ST_DONE) && owner_q;
  assign gbc.busy       = (state_q != ST_IDLE);
`ifdef GBC_TIMEOUT_EN
  assign gbc.timeout_err = terr_q;
`else
  assign gbc.timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_grant_burst_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_grant_burst_ctrl : directed vector table plus reset/stall sequences.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_grant_burst_ctrl;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_err;

  grant_burst_ctrl_if #(.DATA_W(8)) gbc ();

  grant_burst_ctrl #(
    .DATA_W      (8),
    .BURST_LEN   (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .gbc   (gbc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       g0;
    logic       g1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       rdy;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {valid, data[7:0], rd0, rd1, owner, done0, done1, busy, timeout_err}
  function automatic logic [15:0] outs();
    return {gbc.bus_valid, gbc.bus_data, gbc.rd_0, gbc.rd_1, gbc.bus_owner,
            gbc.done_0, gbc.done_1, gbc.busy, gbc.timeout_err};
  endfunction

  function automatic logic [15:0] mk(logic v, logic [7:0] d, logic r0, logic r1,
                                     logic o, logic dn0, logic dn1, logic b);
    return {v, d, r0, r1, o, dn0, dn1, b, 1'b0};
  endfunction

  task automatic add(logic g0, logic g1, logic [7:0] d0, logic [7:0] d1, logic rdy,
                     logic [15:0] e);
    vec_t r;
    r.g0 = g0; r.g1 = g1; r.d0 = d0; r.d1 = d1; r.rdy = rdy; r.exp = e;
    vecs.push_back(r);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cnt, dn0_cnt, dn1_cnt, bad;
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    gbc.gnt_0 = 0; gbc.gnt_1 = 0; gbc.data_0 = 0; gbc.data_1 = 0; gbc.bus_ready = 0;

    // burst from requester 0, stepping data
    add(1,0,8'h10,8'h00,1, mk(0,8'h10,0,0,0,0,0,0));
    add(0,0,8'h10,8'h00,1, mk(1,8'h10,1,0,0,0,0,1));
    add(0,0,8'h11,8'h00,1, mk(1,8'h11,1,0,0,0,0,1));
    add(0,0,8'h12,8'h00,1, mk(1,8'h12,1,0,0,0,0,1));
    add(0,0,8'h13,8'h00,1, mk(1,8'h13,1,0,0,0,0,1));
    add(0,0,8'h00,8'h00,1, mk(0,8'h00,0,0,0,1,0,1));
    add(0,0,8'h00,8'h00,1, mk(0,8'h00,0,0,0,0,0,0));
    // one-cycle gnt_1 pulse with ready toggling
    add(0,1,8'h00,8'hA0,1, mk(0,8'h00,0,0,0,0,0,0));
    add(0,0,8'h00,8'hA0,0, mk(1,8'hA0,0,0,1,0,0,1));
    add(0,0,8'h00,8'hA0,1, mk(1,8'hA0,0,1,1,0,0,1));
    add(0,0,8'h00,8'hA1,0, mk(1,8'hA1,0,0,1,0,0,1));
    add(0,0,8'h00,8'hA1,1, mk(1,8'hA1,0,1,1,0,0,1));
    add(0,0,8'h00,8'hA2,0, mk(1,8'hA2,0,0,1,0,0,1));
    add(0,0,8'h00,8'hA2,1, mk(1,8'hA2,0,1,1,0,0,1));
    add(0,0,8'h00,8'hA3,0, mk(1,8'hA3,0,0,1,0,0,1));
    add(0,0,8'h00,8'hA3,1, mk(1,8'hA3,0,1,1,0,0,1));
    add(0,0,8'h00,8'hA3,1, mk(0,8'hA3,0,0,1,0,1,1));
    // both grants: gnt_0 wins; switch to gnt_1 mid-burst keeps owner 0
    add(1,1,8'h20,8'h55,1, mk(0,8'h55,0,0,1,0,0,0));
    add(0,1,8'h20,8'h55,1, mk(1,8'h20,1,0,0,0,0,1));
    add(0,1,8'h21,8'h55,1, mk(1,8'h21,1,0,0,0,0,1));
    add(0,1,8'h22,8'h55,1, mk(1,8'h22,1,0,0,0,0,1));
    add(0,1,8'h23,8'h55,1, mk(1,8'h23,1,0,0,0,0,1));
    add(0,1,8'h23,8'h55,1, mk(0,8'h23,0,0,0,1,0,1));
    add(0,1,8'h23,8'h55,1, mk(0,8'h23,0,0,0,0,0,0));
    add(0,0,8'h23,8'h30,1, mk(1,8'h30,0,1,1,0,0,1));
    add(0,0,8'h23,8'h31,1, mk(1,8'h31,0,1,1,0,0,1));
    add(0,0,8'h23,8'h32,1, mk(1,8'h32,0,1,1,0,0,1));
    add(0,0,8'h23,8'h33,1, mk(1,8'h33,0,1,1,0,0,1));
    add(0,0,8'h23,8'h33,1, mk(0,8'h33,0,0,1,0,1,1));
    add(0,0,8'h23,8'h33,1, mk(0,8'h33,0,0,1,0,0,0));

    tick();
    tick();
    chk("reset_state", 32'(outs()), 32'h0);
    reset = 1'b0;
    #1;
    chk("after_release", 32'(outs()), 32'h0);

    foreach (vecs[i]) begin
      gbc.gnt_0 = vecs[i].g0; gbc.gnt_1 = vecs[i].g1;
      gbc.data_0 = vecs[i].d0; gbc.data_1 = vecs[i].d1;
      gbc.bus_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      tick();
    end

    // reset at beat 2, grant held through reset
    gbc.gnt_0 = 1; gbc.gnt_1 = 0; gbc.bus_ready = 1; gbc.data_0 = 8'h40;
    tick();
    tick();
    tick();
    chk("pre_reset_xfer", 32'({gbc.bus_valid, gbc.rd_0}), 32'b11);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", 32'({gbc.bus_valid, gbc.busy, gbc.rd_0, gbc.rd_1,
                            gbc.done_0, gbc.done_1, gbc.bus_owner}), 32'h0);
    tick();
    chk("reset_held", 32'({gbc.bus_valid, gbc.busy, gbc.done_0, gbc.done_1}), 32'h0);
    reset = 1'b0;
    #1;
    chk("released_idle", 32'({gbc.bus_valid, gbc.busy}), 32'h0);
    tick();
    chk("restart_first_edge", 32'({gbc.bus_valid, gbc.bus_owner}), 32'b10);
    gbc.gnt_0 = 0;
    rd_cnt = 0; dn0_cnt = 0; dn1_cnt = 0;
    for (int c = 0; c < 12 && dn0_cnt == 0; c++) begin
      #1;
      if (gbc.rd_0) rd_cnt++;
      if (gbc.done_0) dn0_cnt++;
      if (gbc.done_1) dn1_cnt++;
      tick();
    end
    chk("restart_beats", 32'(rd_cnt), 32'd4);
    chk("restart_done0", 32'(dn0_cnt), 32'd1);
    chk("restart_done1", 32'(dn1_cnt), 32'd0);

    // long stall
    gbc.gnt_0 = 1; gbc.bus_ready = 0;
    tick();
    gbc.gnt_0 = 0;
`ifdef GBC_TIMEOUT_EN
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      if (!gbc.bus_valid || gbc.done_0 || gbc.timeout_err) bad++;
      tick();
    end
    chk("stall_16_cycles", 32'(bad), 32'd0);
    chk("timeout_done", 32'({gbc.bus_valid, gbc.done_0, gbc.timeout_err}), 32'b011);
    tick();
    gbc.gnt_0 = 1; gbc.bus_ready = 1;
    tick();
    gbc.gnt_0 = 0;
    rd_cnt = 0; dn0_cnt = 0;
    for (int c = 0; c < 12 && dn0_cnt == 0; c++) begin
      if (gbc.rd_0) rd_cnt++;
      if (gbc.done_0) dn0_cnt++;
      tick();
    end
    chk("post_timeout_beats", 32'(rd_cnt), 32'd4);
    chk("timeout_sticky", 32'(gbc.timeout_err), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("timeout_cleared", 32'(gbc.timeout_err), 32'd0);
    tick();
    reset = 1'b0;
`else
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (!gbc.bus_valid || !gbc.busy || gbc.rd_0 || gbc.done_0 || gbc.timeout_err) bad++;
      tick();
    end
    chk("stall_100_cycles", 32'(bad), 32'd0);
    gbc.bus_ready = 1;
    rd_cnt = 0; dn0_cnt = 0; bad = 0;
    for (int c = 0; c < 12 && dn0_cnt == 0; c++) begin
      #1;
      if (gbc.rd_0) rd_cnt++;
      if (gbc.done_0) dn0_cnt++;
      if (gbc.timeout_err) bad++;
      tick();
    end
    chk("stall_release_beats", 32'(rd_cnt), 32'd4);
    chk("stall_release_done", 32'(dn0_cnt), 32'd1);
    chk("no_timeout_err", 32'(bad), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
